// File: rtl/rs_pkg.sv
// ============================================================================
//  Module   : rs_pkg
//  Purpose  : Shared widths and entry/operand record types for rs_multi_entry.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package rs_pkg;

    localparam int c_RS_DEPTH  = 8;
    localparam int c_DISP_W    = 2;
    localparam int c_CDB_W     = 2;
    localparam int c_ISSUE_W   = 2;
    localparam int c_TAG_W     = 5;
    localparam int c_XLEN      = 32;
    localparam int c_PAYLOAD_W = 64;

    typedef struct packed {
        logic                ready;
        logic [c_TAG_W-1:0]  tag;
        logic [c_XLEN-1:0]   value;
    } rs_operand_t;

    typedef struct packed {
        logic                   busy;
        logic [c_PAYLOAD_W-1:0] payload;
        logic [c_TAG_W-1:0]     dest_tag;
        rs_operand_t            rs1;
        rs_operand_t            rs2;
    } rs_entry_t;

    typedef struct packed {
        logic              hit;
        logic [c_XLEN-1:0] value;
    } rs_cdb_t;

endpackage

`default_nettype wire

// File: rtl/rs_age_select.sv
// ============================================================================
//  Module   : rs_age_select
//  Purpose  : Oldest-first select of up to PORTS requesters from an age matrix.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_age_select #(
    parameter int DEPTH = 8,
    parameter int PORTS = 2
) (
    input  logic [DEPTH-1:0]            i_req,
    input  logic [DEPTH-1:0][DEPTH-1:0] i_age,
    output logic [PORTS-1:0][DEPTH-1:0] o_grant
);

    localparam int c_RW = $clog2(DEPTH + 1);

    logic [c_RW-1:0] w_rank [DEPTH];

    // A requester's rank is the number of older requesters; rank p goes to port p.
    always_comb begin
        o_grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rank[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                w_rank[i] = w_rank[i] + c_RW'(i_age[i][j] & i_req[j]);
            end
            for (int p = 0; p < PORTS; p++) begin
                if (i_req[i] && (w_rank[i] == c_RW'(p))) begin
                    o_grant[p][i] = 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rs_multi_entry.sv
// ============================================================================
//  Module   : rs_multi_entry
//  Purpose  : Age-ordered multi-port reservation station with CDB wakeup.
//             Optional same-cycle CDB-to-issue forwarding: RS_CDB_BYPASS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rs_multi_entry
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = c_RS_DEPTH,
    parameter int DISP_W   = c_DISP_W,
    parameter int CDB_W    = c_CDB_W,
    parameter int ISSUE_W  = c_ISSUE_W
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_squash,
    input  logic [DISP_W-1:0]                 i_disp_valid,
    input  logic [DISP_W*c_PAYLOAD_W-1:0]     i_disp_payload,
    input  logic [DISP_W*c_TAG_W-1:0]         i_disp_dest_tag,
    input  logic [DISP_W-1:0]                 i_disp_rs1_ready,
    input  logic [DISP_W*c_TAG_W-1:0]         i_disp_rs1_tag,
    input  logic [DISP_W*c_XLEN-1:0]          i_disp_rs1_value,
    input  logic [DISP_W-1:0]                 i_disp_rs2_ready,
    input  logic [DISP_W*c_TAG_W-1:0]         i_disp_rs2_tag,
    input  logic [DISP_W*c_XLEN-1:0]          i_disp_rs2_value,
    output logic                              o_disp_ready,
    output logic [$clog2(RS_DEPTH+1)-1:0]     o_free_cnt,
    input  logic [CDB_W-1:0]                  i_cdb_valid,
    input  logic [CDB_W*c_TAG_W-1:0]          i_cdb_tag,
    input  logic [CDB_W*c_XLEN-1:0]           i_cdb_value,
    input  logic [ISSUE_W-1:0]                i_issue_ready,
    output logic [ISSUE_W-1:0]                o_issue_valid,
    output logic [ISSUE_W*c_PAYLOAD_W-1:0]    o_issue_payload,
    output logic [ISSUE_W*c_TAG_W-1:0]        o_issue_dest_tag,
    output logic [ISSUE_W*c_XLEN-1:0]         o_issue_rs1_value,
    output logic [ISSUE_W*c_XLEN-1:0]         o_issue_rs2_value
);

    localparam int c_CW = $clog2(RS_DEPTH + 1);
    localparam int c_IW = $clog2(RS_DEPTH);

    rs_entry_t                         r_entry     [RS_DEPTH];
    rs_entry_t                         w_entry_nxt [RS_DEPTH];
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] r_age;
    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] w_age_nxt;
    logic [c_CW-1:0]                   r_free_cnt;
    logic [c_CW-1:0]                   w_free_nxt;

    logic [RS_DEPTH-1:0]               w_busy;
    logic [RS_DEPTH-1:0]               w_wake1;
    logic [RS_DEPTH-1:0]               w_wake2;
    logic [RS_DEPTH-1:0]               w_req;
    logic [RS_DEPTH-1:0]               w_free_vec;
    rs_cdb_t                           w_look1   [RS_DEPTH];
    rs_cdb_t                           w_look2   [RS_DEPTH];
    logic [c_XLEN-1:0]                 w_rs1_eff [RS_DEPTH];
    logic [c_XLEN-1:0]                 w_rs2_eff [RS_DEPTH];
    logic [ISSUE_W-1:0][RS_DEPTH-1:0]  w_grant;
    logic [ISSUE_W-1:0]                w_fire;

    logic                              w_disp_acc;
    logic [DISP_W-1:0]                 w_alloc_en;
    logic [c_IW-1:0]                   w_alloc_idx [DISP_W];
    logic [RS_DEPTH-1:0]               w_alloc_row [DISP_W];

    // Lowest-index matching channel wins, hence the descending scan.
    function automatic rs_cdb_t cdb_lookup(
        input logic [CDB_W-1:0]         valid,
        input logic [CDB_W*c_TAG_W-1:0] tags,
        input logic [CDB_W*c_XLEN-1:0]  values,
        input logic [c_TAG_W-1:0]       tag
    );
        rs_cdb_t res;
        res = '0;
        for (int c = CDB_W - 1; c >= 0; c--) begin
            if (valid[c] && (tags[c*c_TAG_W +: c_TAG_W] == tag)) begin
                res.hit   = 1'b1;
                res.value = values[c*c_XLEN +: c_XLEN];
            end
        end
        return res;
    endfunction

    function automatic rs_operand_t capture(
        input logic               rdy,
        input logic [c_TAG_W-1:0] tag,
        input logic [c_XLEN-1:0]  value,
        input rs_cdb_t            look
    );
        rs_operand_t op;
        op.tag = tag;
        if (rdy) begin
            op.ready = 1'b1;
            op.value = value;
        end else if (look.hit) begin
            op.ready = 1'b1;
            op.value = look.value;
        end else begin
            op.ready = 1'b0;
            op.value = '0;
        end
        return op;
    endfunction

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_busy[i]  = r_entry[i].busy;
            w_look1[i] = cdb_lookup(i_cdb_valid, i_cdb_tag, i_cdb_value, r_entry[i].rs1.tag);
            w_look2[i] = cdb_lookup(i_cdb_valid, i_cdb_tag, i_cdb_value, r_entry[i].rs2.tag);
            w_wake1[i] = r_entry[i].busy && !r_entry[i].rs1.ready && w_look1[i].hit;
            w_wake2[i] = r_entry[i].busy && !r_entry[i].rs2.ready && w_look2[i].hit;
`ifdef RS_CDB_BYPASS_EN
            w_req[i]     = r_entry[i].busy
                         && (r_entry[i].rs1.ready || w_wake1[i])
                         && (r_entry[i].rs2.ready || w_wake2[i]);
            w_rs1_eff[i] = r_entry[i].rs1.ready ? r_entry[i].rs1.value : w_look1[i].value;
            w_rs2_eff[i] = r_entry[i].rs2.ready ? r_entry[i].rs2.value : w_look2[i].value;
`else
            w_req[i]     = r_entry[i].busy && r_entry[i].rs1.ready && r_entry[i].rs2.ready;
            w_rs1_eff[i] = r_entry[i].rs1.value;
            w_rs2_eff[i] = r_entry[i].rs2.value;
`endif
        end
    end

    rs_age_select #(
        .DEPTH (RS_DEPTH),
        .PORTS (ISSUE_W)
    ) u_age_select (
        .i_req   (w_req),
        .i_age   (r_age),
        .o_grant (w_grant)
    );

    always_comb begin
        o_issue_valid     = '0;
        o_issue_payload   = '0;
        o_issue_dest_tag  = '0;
        o_issue_rs1_value = '0;
        o_issue_rs2_value = '0;
        w_fire            = '0;
        w_free_vec        = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            o_issue_valid[p] = |w_grant[p];
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (w_grant[p][i]) begin
                    o_issue_payload[p*c_PAYLOAD_W +: c_PAYLOAD_W] = r_entry[i].payload;
                    o_issue_dest_tag[p*c_TAG_W +: c_TAG_W]        = r_entry[i].dest_tag;
                    o_issue_rs1_value[p*c_XLEN +: c_XLEN]         = w_rs1_eff[i];
                    o_issue_rs2_value[p*c_XLEN +: c_XLEN]         = w_rs2_eff[i];
                end
            end
            w_fire[p] = o_issue_valid[p] && i_issue_ready[p] && !i_squash;
            if (w_fire[p]) begin
                w_free_vec = w_free_vec | w_grant[p];
            end
        end
    end

    // Allocation only sees registered busy bits, so slots freed this cycle stay hidden.
    always_comb begin
        logic [RS_DEPTH-1:0] taken;
        taken        = '0;
        o_disp_ready = (r_free_cnt >= c_CW'(DISP_W));
        w_disp_acc   = o_disp_ready && !i_squash;
        for (int d = 0; d < DISP_W; d++) begin
            w_alloc_en[d]  = 1'b0;
            w_alloc_idx[d] = '0;
            w_alloc_row[d] = w_busy | taken;
            if (w_disp_acc && i_disp_valid[d]) begin
                for (int i = RS_DEPTH - 1; i >= 0; i--) begin
                    if (!(w_busy[i] || taken[i])) begin
                        w_alloc_idx[d] = c_IW'(i);
                    end
                end
                w_alloc_en[d] = ~&(w_busy | taken);
                taken[w_alloc_idx[d]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_free_nxt = r_free_cnt;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_entry_nxt[i] = r_entry[i];
            w_age_nxt[i]   = r_age[i];
            if (w_wake1[i]) begin
                w_entry_nxt[i].rs1.ready = 1'b1;
                w_entry_nxt[i].rs1.value = w_look1[i].value;
            end
            if (w_wake2[i]) begin
                w_entry_nxt[i].rs2.ready = 1'b1;
                w_entry_nxt[i].rs2.value = w_look2[i].value;
            end
            if (w_free_vec[i]) begin
                w_entry_nxt[i].busy = 1'b0;
            end
        end
        for (int d = 0; d < DISP_W; d++) begin
            if (w_alloc_en[d]) begin
                w_entry_nxt[w_alloc_idx[d]].busy     = 1'b1;
                w_entry_nxt[w_alloc_idx[d]].payload  = i_disp_payload[d*c_PAYLOAD_W +: c_PAYLOAD_W];
                w_entry_nxt[w_alloc_idx[d]].dest_tag = i_disp_dest_tag[d*c_TAG_W +: c_TAG_W];
                w_entry_nxt[w_alloc_idx[d]].rs1      = capture(
                    i_disp_rs1_ready[d], i_disp_rs1_tag[d*c_TAG_W +: c_TAG_W],
                    i_disp_rs1_value[d*c_XLEN +: c_XLEN],
                    cdb_lookup(i_cdb_valid, i_cdb_tag, i_cdb_value,
                               i_disp_rs1_tag[d*c_TAG_W +: c_TAG_W]));
                w_entry_nxt[w_alloc_idx[d]].rs2      = capture(
                    i_disp_rs2_ready[d], i_disp_rs2_tag[d*c_TAG_W +: c_TAG_W],
                    i_disp_rs2_value[d*c_XLEN +: c_XLEN],
                    cdb_lookup(i_cdb_valid, i_cdb_tag, i_cdb_value,
                               i_disp_rs2_tag[d*c_TAG_W +: c_TAG_W]));
                w_age_nxt[w_alloc_idx[d]] = w_alloc_row[d];
                w_free_nxt = w_free_nxt - c_CW'(1);
            end
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            if (w_fire[p]) begin
                w_free_nxt = w_free_nxt + c_CW'(1);
            end
        end
        // Column clear applies after row set so a new row never points at a freed slot.
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (w_free_vec[j]) begin
                    w_age_nxt[i][j] = 1'b0;
                end
            end
        end
        if (i_squash) begin
            w_free_nxt = c_CW'(RS_DEPTH);
            w_age_nxt  = '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                w_entry_nxt[i].busy = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_free_cnt <= c_CW'(RS_DEPTH);
            r_age      <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_free_cnt <= w_free_nxt;
            r_age      <= w_age_nxt;
            for (int i = 0; i < RS_DEPTH; i++) begin
                r_entry[i] <= w_entry_nxt[i];
            end
        end
    end

    assign o_free_cnt = r_free_cnt;

endmodule

`default_nettype wire
